// File: rtl/traffic_light_monitor.sv
// Lamp-drive checker: decodes red/yellow/green into a phase, times each phase and latches the first fault.
// Optional macro TLM_CYCLE_COUNT_EN adds a cycle_count output counting YELLOW->RED transitions in RUN.
module traffic_light_monitor #(
   parameter int MIN_RED    = 4,
   parameter int MIN_GREEN  = 4,
   parameter int MIN_YELLOW = 2,
   parameter int MAX_PHASE  = 31
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       clear,
   input  logic       red,
   input  logic       yellow,
   input  logic       green,
   output logic [1:0] phase,
   output logic [4:0] phase_time,
   output logic       locked,
   output logic       fault,
`ifdef TLM_CYCLE_COUNT_EN
   output logic [7:0] cycle_count,
`endif
   output logic [2:0] fault_code
);

   typedef enum logic [1:0] {S_SYNC, S_RUN, S_FAULT} state_e;

   localparam logic [1:0] PH_DARK   = 2'b00;
   localparam logic [1:0] PH_RED    = 2'b01;
   localparam logic [1:0] PH_GREEN  = 2'b10;
   localparam logic [1:0] PH_YELLOW = 2'b11;

   localparam logic [2:0] FC_NONE  = 3'd0;
   localparam logic [2:0] FC_MULTI = 3'd1;
   localparam logic [2:0] FC_SEQ   = 3'd2;
   localparam logic [2:0] FC_SHORT = 3'd3;
   localparam logic [2:0] FC_LONG  = 3'd4;
   localparam logic [2:0] FC_DARK  = 3'd5;

   localparam logic [4:0] MIN_RED_T    = 5'(MIN_RED);
   localparam logic [4:0] MIN_GREEN_T  = 5'(MIN_GREEN);
   localparam logic [4:0] MIN_YELLOW_T = 5'(MIN_YELLOW);
   localparam logic [4:0] MAX_PHASE_T  = 5'(MAX_PHASE);

   logic [2:0] lamps_q, lamps_d;
   logic       en_q, en_d;
   logic [1:0] phase_q, phase_d;
   logic [4:0] phase_time_q, phase_time_d;
   state_e     state_q, state_d;
   logic       fault_q, fault_d;
   logic [2:0] fault_code_q, fault_code_d;
`ifdef TLM_CYCLE_COUNT_EN
   logic [7:0] cycle_count_q, cycle_count_d;
`endif

   logic [1:0] dec_phase;
   logic       multi;
   logic       chg;
   logic       legal;
   logic       resume;
   logic [4:0] min_time;
   logic [2:0] det;

   // A MULTI pattern carries no phase information, so the decoded phase holds.
   always_comb begin
      multi     = 1'b0;
      dec_phase = phase_q;
      case (lamps_q)
         3'b000:  dec_phase = PH_DARK;
         3'b100:  dec_phase = PH_RED;
         3'b010:  dec_phase = PH_YELLOW;
         3'b001:  dec_phase = PH_GREEN;
         default: multi     = 1'b1;
      endcase
      chg    = !multi && (dec_phase != phase_q);
      legal  = (phase_q == PH_RED    && dec_phase == PH_GREEN)  ||
               (phase_q == PH_GREEN  && dec_phase == PH_YELLOW) ||
               (phase_q == PH_YELLOW && dec_phase == PH_RED);
      resume = enable && !en_q;
      case (phase_q)
         PH_RED:    min_time = MIN_RED_T;
         PH_GREEN:  min_time = MIN_GREEN_T;
         PH_YELLOW: min_time = MIN_YELLOW_T;
         default:   min_time = 5'd0;
      endcase
   end

   always_comb begin
      lamps_d      = lamps_q;
      en_d         = enable;
      phase_d      = phase_q;
      phase_time_d = phase_time_q;
      state_d      = state_q;
      fault_d      = fault_q;
      fault_code_d = fault_code_q;
      det          = FC_NONE;
`ifdef TLM_CYCLE_COUNT_EN
      cycle_count_d = cycle_count_q;
`endif
      if (enable) begin
         lamps_d = {red, yellow, green};
         phase_d = dec_phase;
         if (resume || chg)
            phase_time_d = 5'd1;
         else if (phase_time_q != 5'd31)
            phase_time_d = phase_time_q + 5'd1;

         if (resume) begin
            if (state_q != S_FAULT)
               state_d = S_SYNC;
         end else begin
            // Priority chain encodes MULTI > DARK > SEQ > SHORT > LONG.
            if (state_q != S_FAULT) begin
               if (multi)
                  det = FC_MULTI;
               else if (state_q == S_RUN) begin
                  if (dec_phase == PH_DARK)
                     det = FC_DARK;
                  else if (chg && !legal)
                     det = FC_SEQ;
                  else if (chg && (phase_time_q < min_time))
                     det = FC_SHORT;
                  else if (!chg && (phase_time_d == MAX_PHASE_T))
                     det = FC_LONG;
               end
            end
            if (det != FC_NONE) begin
               state_d      = S_FAULT;
               fault_d      = 1'b1;
               fault_code_d = det;
            end else if (state_q == S_SYNC && chg &&
                         phase_q == PH_RED && dec_phase == PH_GREEN) begin
               state_d = S_RUN;
            end
`ifdef TLM_CYCLE_COUNT_EN
            if (state_q == S_RUN && chg && phase_q == PH_YELLOW && dec_phase == PH_RED)
               cycle_count_d = cycle_count_q + 8'd1;
`endif
         end
      end

      if (clear) begin
         state_d      = S_SYNC;
         fault_d      = 1'b0;
         fault_code_d = FC_NONE;
`ifdef TLM_CYCLE_COUNT_EN
         cycle_count_d = 8'd0;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lamps_q      <= 3'b000;
         en_q         <= 1'b1;
         phase_q      <= PH_DARK;
         phase_time_q <= 5'd0;
         state_q      <= S_SYNC;
         fault_q      <= 1'b0;
         fault_code_q <= FC_NONE;
`ifdef TLM_CYCLE_COUNT_EN
         cycle_count_q <= 8'd0;
`endif
      end else begin
         lamps_q      <= lamps_d;
         en_q         <= en_d;
         phase_q      <= phase_d;
         phase_time_q <= phase_time_d;
         state_q      <= state_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
`ifdef TLM_CYCLE_COUNT_EN
         cycle_count_q <= cycle_count_d;
`endif
      end
   end

   assign phase      = phase_q;
   assign phase_time = phase_time_q;
   assign locked     = (state_q == S_RUN);
   assign fault      = fault_q;
   assign fault_code = fault_code_q;
`ifdef TLM_CYCLE_COUNT_EN
   assign cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed, table-driven bench for traffic_light_monitor; expected values are hand-computed per segment.
module tb_traffic_light_monitor;

   localparam logic [2:0] L_D  = 3'b000;
   localparam logic [2:0] L_R  = 3'b100;
   localparam logic [2:0] L_Y  = 3'b010;
   localparam logic [2:0] L_G  = 3'b001;
   localparam logic [2:0] L_RG = 3'b101;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       clear;
   logic       red, yellow, green;
   logic [1:0] phase;
   logic [4:0] phase_time;
   logic       locked;
   logic       fault;
   logic [2:0] fault_code;
`ifdef TLM_CYCLE_COUNT_EN
   logic [7:0] cycle_count;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] lamps;
      logic       en;
      logic       clr;
      int         n;
      logic [1:0] ph;
      logic [4:0] pt;
      logic       lk;
      logic       flt;
      logic [2:0] code;
   } seg_t;

   seg_t segs[$];

   traffic_light_monitor dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .clear      (clear),
      .red        (red),
      .yellow     (yellow),
      .green      (green),
      .phase      (phase),
      .phase_time (phase_time),
      .locked     (locked),
      .fault      (fault),
`ifdef TLM_CYCLE_COUNT_EN
      .cycle_count(cycle_count),
`endif
      .fault_code (fault_code)
   );

   always #5 clk = ~clk;

   function automatic seg_t mk(input logic [2:0] lamps, input logic en, input logic clr,
                               input int n, input logic [1:0] ph, input logic [4:0] pt,
                               input logic lk, input logic flt, input logic [2:0] code);
      seg_t s;
      s.lamps = lamps; s.en = en; s.clr = clr; s.n = n;
      s.ph = ph; s.pt = pt; s.lk = lk; s.flt = flt; s.code = code;
      return s;
   endfunction

   task automatic check_output(input string name, input int idx,
                               input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   // Drives the lamps for n clock edges, changing inputs on the falling edge.
   task automatic apply_stimulus(input logic [2:0] lamps, input logic en,
                                 input logic clr, input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         {red, yellow, green} = lamps;
         enable = en;
         clear  = clr;
         @(posedge clk);
      end
      #1;
   endtask

   task automatic check_all(input int idx, input logic [1:0] ph, input logic [4:0] pt,
                            input logic lk, input logic flt, input logic [2:0] code);
      check_output("phase",      idx, 8'(phase),      8'(ph));
      check_output("phase_time", idx, 8'(phase_time), 8'(pt));
      check_output("locked",     idx, 8'(locked),     8'(lk));
      check_output("fault",      idx, 8'(fault),      8'(flt));
      check_output("fault_code", idx, 8'(fault_code), 8'(code));
   endtask

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      enable  = 1'b1;
      clear   = 1'b0;
      {red, yellow, green} = L_D;

      // Legal run, three full cycles; lock on first RED->GREEN.
      for (int k = 0; k < 3; k++) begin
         segs.push_back(mk(L_R, 1, 0, 5, 2'b01, 5'd4, k != 0, 0, 0));
         segs.push_back(mk(L_G, 1, 0, 6, 2'b10, 5'd5, 1, 0, 0));
         segs.push_back(mk(L_Y, 1, 0, 3, 2'b11, 5'd2, 1, 0, 0));
      end
      // MULTI while locked, then DARK does not overwrite the code.
      segs.push_back(mk(L_R,  1, 0, 5, 2'b01, 5'd4, 1, 0, 0));
      segs.push_back(mk(L_RG, 1, 0, 1, 2'b01, 5'd5, 1, 0, 0));
      segs.push_back(mk(L_D,  1, 0, 1, 2'b01, 5'd6, 0, 1, 1));
      segs.push_back(mk(L_D,  1, 0, 3, 2'b00, 5'd3, 0, 1, 1));
      // Clear, relock, short GREEN.
      segs.push_back(mk(L_D,  1, 1, 1, 2'b00, 5'd4, 0, 0, 0));
      segs.push_back(mk(L_R,  1, 0, 5, 2'b01, 5'd4, 0, 0, 0));
      segs.push_back(mk(L_G,  1, 0, 2, 2'b10, 5'd1, 1, 0, 0));
      segs.push_back(mk(L_Y,  1, 0, 3, 2'b11, 5'd2, 0, 1, 3));
      segs.push_back(mk(L_Y,  1, 1, 1, 2'b11, 5'd3, 0, 0, 0));
      segs.push_back(mk(L_R,  1, 0, 5, 2'b01, 5'd4, 0, 0, 0));
      segs.push_back(mk(L_G,  1, 0, 6, 2'b10, 5'd5, 1, 0, 0));
      // RED directly to YELLOW.
      segs.push_back(mk(L_Y,  1, 0, 3, 2'b11, 5'd2, 1, 0, 0));
      segs.push_back(mk(L_R,  1, 0, 5, 2'b01, 5'd4, 1, 0, 0));
      segs.push_back(mk(L_Y,  1, 0, 2, 2'b11, 5'd1, 0, 1, 2));
      // Long RED: LONG fires as phase_time hits 31, which then saturates.
      segs.push_back(mk(L_Y,  1, 1, 1, 2'b11, 5'd2, 0, 0, 0));
      segs.push_back(mk(L_R,  1, 0, 5, 2'b01, 5'd4, 0, 0, 0));
      segs.push_back(mk(L_G,  1, 0, 6, 2'b10, 5'd5, 1, 0, 0));
      segs.push_back(mk(L_Y,  1, 0, 3, 2'b11, 5'd2, 1, 0, 0));
      segs.push_back(mk(L_R,  1, 0, 31, 2'b01, 5'd30, 1, 0, 0));
      segs.push_back(mk(L_R,  1, 0, 1, 2'b01, 5'd31, 0, 1, 4));
      segs.push_back(mk(L_R,  1, 0, 8, 2'b01, 5'd31, 0, 1, 4));
      // Enable low while dark: frozen; resume drops lock and restarts timing.
      segs.push_back(mk(L_R,  1, 1, 1, 2'b01, 5'd31, 0, 0, 0));
      segs.push_back(mk(L_G,  1, 0, 6, 2'b10, 5'd5, 1, 0, 0));
      segs.push_back(mk(L_Y,  1, 0, 3, 2'b11, 5'd2, 1, 0, 0));
      segs.push_back(mk(L_R,  1, 0, 5, 2'b01, 5'd4, 1, 0, 0));
      segs.push_back(mk(L_D,  0, 0, 10, 2'b01, 5'd4, 1, 0, 0));
      segs.push_back(mk(L_R,  1, 0, 1, 2'b01, 5'd1, 0, 0, 0));
      segs.push_back(mk(L_R,  1, 0, 3, 2'b01, 5'd4, 0, 0, 0));
      segs.push_back(mk(L_G,  1, 0, 2, 2'b10, 5'd1, 1, 0, 0));

      repeat (2) @(negedge clk);
      #1;
      check_all(-1, 2'b00, 5'd0, 0, 0, 0);
      @(negedge clk);
      reset_n = 1'b1;

      foreach (segs[i]) begin
         apply_stimulus(segs[i].lamps, segs[i].en, segs[i].clr, segs[i].n);
         check_all(i, segs[i].ph, segs[i].pt, segs[i].lk, segs[i].flt, segs[i].code);
      end

      // Asynchronous reset in the middle of GREEN, between clock edges.
      apply_stimulus(L_G, 1, 0, 2);
      #2;
      reset_n = 1'b0;
      #1;
      check_all(1000, 2'b00, 5'd0, 0, 0, 0);
      @(negedge clk);
      reset_n = 1'b1;

`ifdef TLM_CYCLE_COUNT_EN
      // 257 YELLOW->RED transitions in RUN wrap the counter to 1.
      for (int k = 0; k < 257; k++) begin
         apply_stimulus(L_R, 1, 0, 5);
         apply_stimulus(L_G, 1, 0, 6);
         apply_stimulus(L_Y, 1, 0, 3);
      end
      apply_stimulus(L_R, 1, 0, 2);
      check_output("cycle_count", 2000, cycle_count, 8'd1);
      check_output("locked",      2000, 8'(locked), 8'd1);
      check_output("fault",       2000, 8'(fault),  8'd0);
      apply_stimulus(L_R, 1, 0, 3);
      apply_stimulus(L_G, 1, 0, 3);
      #2;
      reset_n = 1'b0;
      #1;
      check_all(2001, 2'b00, 5'd0, 0, 0, 0);
      check_output("cycle_count", 2001, cycle_count, 8'd0);
      @(negedge clk);
      reset_n = 1'b1;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
